// File: rtl/driver_receiver_if.sv
// Purpose : bundles the LED-driver serial lines (sclk/gclk/lat/sin) and the
//           decoded receiver outputs into one interface.
// Modports: master - drives the serial lines, observes decoded outputs
//           slave  - the receiver: samples the serial lines, drives outputs
// Signals : sclk, gclk, lat, sin           serial driver lines
//           gs_word[47:0], gs_index[3:0]   last GS word and its slot
//           gs_valid, latgs_pulse          one-cycle GS write / latch pulses
//           gclk_count[GCLK_W-1:0]         gclk rises between last two LATGS
//           fc_data[47:0], fc_valid        function-control register + pulse
//           cmd_error, gs_overflow         bad command pulse / sticky overflow
interface driver_receiver_if #(
    parameter int unsigned GCLK_W = 16
);
    logic              sclk;
    logic              gclk;
    logic              lat;
    logic              sin;
    logic [47:0]       gs_word;
    logic [3:0]        gs_index;
    logic              gs_valid;
    logic              latgs_pulse;
    logic [GCLK_W-1:0] gclk_count;
    logic [47:0]       fc_data;
    logic              fc_valid;
    logic              cmd_error;
    logic              gs_overflow;

    modport master (
        output sclk, gclk, lat, sin,
        input  gs_word, gs_index, gs_valid, latgs_pulse, gclk_count,
               fc_data, fc_valid, cmd_error, gs_overflow
    );

    modport slave (
        input  sclk, gclk, lat, sin,
        output gs_word, gs_index, gs_valid, latgs_pulse, gclk_count,
               fc_data, fc_valid, cmd_error, gs_overflow
    );
endinterface

// File: rtl/driver_receiver.sv
// Purpose : receiver for an LED-driver style serial protocol. Shifts sin on
//           sclk rises, counts sclk rises while lat is high, and decodes the
//           command from that count when lat falls (WRTGS, LATGS, WRTFC,
//           LINERESET, READFC, TMGRST, FCWRTEN). Also counts gclk rises per
//           LATGS interval.
// Ports   : clk  - system clock (rising edge)
//           rst  - synchronous active-high reset
//           bus  - driver_receiver_if.slave (serial inputs, decoded outputs)
module driver_receiver #(
    parameter int unsigned GS_WORDS = 9,
    parameter int unsigned GCLK_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    driver_receiver_if.slave bus
);
    localparam int unsigned WORD_W = 48;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned IDX_W  = 4;

    localparam logic [CNT_W-1:0] CNT_MAX       = CNT_W'(31);
    localparam logic [CNT_W-1:0] CMD_WRTGS     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CMD_LATGS     = CNT_W'(3);
    localparam logic [CNT_W-1:0] CMD_WRTFC     = CNT_W'(5);
    localparam logic [CNT_W-1:0] CMD_LINERESET = CNT_W'(7);
    localparam logic [CNT_W-1:0] CMD_READFC    = CNT_W'(11);
    localparam logic [CNT_W-1:0] CMD_TMGRST    = CNT_W'(13);
    localparam logic [CNT_W-1:0] CMD_FCWRTEN   = CNT_W'(15);
    localparam logic [IDX_W-1:0] IDX_FULL      = IDX_W'(GS_WORDS);

    logic                sclk_q, gclk_q, lat_q;
    logic [WORD_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
    logic                fc_wen_q, fc_wen_d;
    logic [GCLK_W-1:0]   gclk_acc_q, gclk_acc_d;

    logic [WORD_W-1:0]   gs_word_q, gs_word_d;
    logic [IDX_W-1:0]    gs_index_q, gs_index_d;
    logic                gs_valid_q, gs_valid_d;
    logic                latgs_q, latgs_d;
    logic [GCLK_W-1:0]   gclk_count_q, gclk_count_d;
    logic [WORD_W-1:0]   fc_data_q, fc_data_d;
    logic                fc_valid_q, fc_valid_d;
    logic                cmd_error_q, cmd_error_d;
    logic                gs_overflow_q, gs_overflow_d;

    logic                sclk_rise_c, gclk_rise_c, lat_fall_c;
    logic [CNT_W-1:0]    cnt_final_c;
    logic [GCLK_W-1:0]   gclk_acc_inc_c;

    assign sclk_rise_c = bus.sclk & ~sclk_q;
    assign gclk_rise_c = bus.gclk & ~gclk_q;
    assign lat_fall_c  = ~bus.lat & lat_q;

    // Command length including an sclk rise landing in the current cycle
    assign cnt_final_c = (sclk_rise_c && (lat_cnt_q != CNT_MAX))
                         ? lat_cnt_q + CNT_W'(1) : lat_cnt_q;

    assign gclk_acc_inc_c = (gclk_acc_q == '1) ? gclk_acc_q
                                               : gclk_acc_q + GCLK_W'(1);

    // Next-state: shifting, counting and command decode on lat fall
    always_comb begin
        sr_d          = sclk_rise_c ? {sr_q[WORD_W-2:0], bus.sin} : sr_q;
        lat_cnt_d     = lat_cnt_q;
        wr_idx_d      = wr_idx_q;
        fc_wen_d      = fc_wen_q;
        gclk_acc_d    = gclk_rise_c ? gclk_acc_inc_c : gclk_acc_q;
        gs_word_d     = gs_word_q;
        gs_index_d    = gs_index_q;
        gs_valid_d    = 1'b0;
        latgs_d       = 1'b0;
        gclk_count_d  = gclk_count_q;
        fc_data_d     = fc_data_q;
        fc_valid_d    = 1'b0;
        cmd_error_d   = 1'b0;
        gs_overflow_d = gs_overflow_q;

        if (lat_fall_c) begin
            lat_cnt_d = '0;
        end else if (sclk_rise_c && bus.lat) begin
            lat_cnt_d = cnt_final_c;
        end

        if (lat_fall_c) begin
            case (cnt_final_c)
                CMD_WRTGS, CMD_LATGS: begin
                    if (wr_idx_q == IDX_FULL) begin
                        gs_overflow_d = 1'b1;
                    end else begin
                        gs_word_d  = sr_d;
                        gs_index_d = wr_idx_q;
                        gs_valid_d = 1'b1;
                        wr_idx_d   = wr_idx_q + IDX_W'(1);
                    end
                    // LATGS closes the gclk interval; a rise this cycle opens the next
                    if (cnt_final_c == CMD_LATGS) begin
                        latgs_d      = 1'b1;
                        wr_idx_d     = '0;
                        gclk_count_d = gclk_acc_q;
                        gclk_acc_d   = GCLK_W'(gclk_rise_c);
                    end
                end
                CMD_WRTFC: begin
                    if (fc_wen_q) begin
                        fc_data_d  = sr_d;
                        fc_valid_d = 1'b1;
                        fc_wen_d   = 1'b0;
                    end
                end
                CMD_LINERESET: begin
                    wr_idx_d   = '0;
                    gclk_acc_d = GCLK_W'(gclk_rise_c);
                end
                CMD_READFC: begin
                    fc_wen_d = fc_wen_q;
                end
                CMD_TMGRST: begin
                    wr_idx_d   = '0;
                    gclk_acc_d = GCLK_W'(gclk_rise_c);
                    fc_wen_d   = 1'b0;
                end
                CMD_FCWRTEN: begin
                    fc_wen_d = 1'b1;
                end
                default: begin
                    cmd_error_d = 1'b1;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q        <= 1'b0;
            gclk_q        <= 1'b0;
            lat_q         <= 1'b0;
            sr_q          <= '0;
            lat_cnt_q     <= '0;
            wr_idx_q      <= '0;
            fc_wen_q      <= 1'b0;
            gclk_acc_q    <= '0;
            gs_word_q     <= '0;
            gs_index_q    <= '0;
            gs_valid_q    <= 1'b0;
            latgs_q       <= 1'b0;
            gclk_count_q  <= '0;
            fc_data_q     <= '0;
            fc_valid_q    <= 1'b0;
            cmd_error_q   <= 1'b0;
            gs_overflow_q <= 1'b0;
        end else begin
            sclk_q        <= bus.sclk;
            gclk_q        <= bus.gclk;
            lat_q         <= bus.lat;
            sr_q          <= sr_d;
            lat_cnt_q     <= lat_cnt_d;
            wr_idx_q      <= wr_idx_d;
            fc_wen_q      <= fc_wen_d;
            gclk_acc_q    <= gclk_acc_d;
            gs_word_q     <= gs_word_d;
            gs_index_q    <= gs_index_d;
            gs_valid_q    <= gs_valid_d;
            latgs_q       <= latgs_d;
            gclk_count_q  <= gclk_count_d;
            fc_data_q     <= fc_data_d;
            fc_valid_q    <= fc_valid_d;
            cmd_error_q   <= cmd_error_d;
            gs_overflow_q <= gs_overflow_d;
        end
    end

    assign bus.gs_word     = gs_word_q;
    assign bus.gs_index    = gs_index_q;
    assign bus.gs_valid    = gs_valid_q;
    assign bus.latgs_pulse = latgs_q;
    assign bus.gclk_count  = gclk_count_q;
    assign bus.fc_data     = fc_data_q;
    assign bus.fc_valid    = fc_valid_q;
    assign bus.cmd_error   = cmd_error_q;
    assign bus.gs_overflow = gs_overflow_q;
endmodule

// File: tb/tb_driver_receiver.sv
// Purpose : self-checking bench for driver_receiver. A directed vector table,
//           hand-written multi-cycle sequences (reset mid-command, GS burst,
//           gclk interval, overflow) and randomized commands checked against
//           a command-level reference model.
module tb_driver_receiver;
    localparam int unsigned GS_WORDS = 9;
    localparam int unsigned GCLK_W   = 16;
    localparam int          ACC_MAX  = 65535;

    logic clk = 1'b0;
    logic rst;

    driver_receiver_if #(.GCLK_W(GCLK_W)) bus ();

    driver_receiver #(
        .GS_WORDS (GS_WORDS),
        .GCLK_W   (GCLK_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: command-level view of the receiver
    logic [47:0] m_sr, m_gs_word, m_fc;
    int          m_idx, m_gs_index, m_acc, m_gclk_count;
    bit          m_wen, m_ovf;
    bit          e_gv, e_lp, e_fv, e_ce;

    typedef struct {
        int          nbits;
        int          latbits;
        logic [47:0] data;
        bit          gv, lp, fv, ce;
        logic [3:0]  idx;
        logic [47:0] word;
        logic [47:0] fc;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input int nb, input int lb, input logic [47:0] d,
                                input bit gv, input bit lp, input bit fv, input bit ce,
                                input logic [3:0] idx, input logic [47:0] w,
                                input logic [47:0] fc);
        vec_t v;
        v.nbits = nb; v.latbits = lb; v.data = d;
        v.gv = gv; v.lp = lp; v.fv = fv; v.ce = ce;
        v.idx = idx; v.word = w; v.fc = fc;
        return v;
    endfunction

    function automatic void model_reset();
        m_sr = '0; m_gs_word = '0; m_fc = '0;
        m_idx = 0; m_gs_index = 0; m_acc = 0; m_gclk_count = 0;
        m_wen = 1'b0; m_ovf = 1'b0;
        e_gv = 1'b0; e_lp = 1'b0; e_fv = 1'b0; e_ce = 1'b0;
    endfunction

    // One frame: nbits shifted MSB first, lat high on the last latbits of them
    function automatic void model_frame(input int nbits, input int latbits,
                                        input logic [47:0] data, input bit gfall);
        int cnt;
        bit restart;
        logic [47:0] mask;
        cnt     = (latbits > 31) ? 31 : latbits;
        restart = 1'b0;
        if (nbits >= 48) begin
            m_sr = data;
        end else begin
            mask = (48'd1 << nbits) - 48'd1;
            m_sr = (m_sr << nbits) | (data & mask);
        end
        e_gv = 1'b0; e_lp = 1'b0; e_fv = 1'b0; e_ce = 1'b0;
        case (cnt)
            1, 3: begin
                if (m_idx == int'(GS_WORDS)) begin
                    m_ovf = 1'b1;
                end else begin
                    m_gs_word  = m_sr;
                    m_gs_index = m_idx;
                    e_gv       = 1'b1;
                    m_idx      = m_idx + 1;
                end
                if (cnt == 3) begin
                    e_lp         = 1'b1;
                    m_idx        = 0;
                    m_gclk_count = m_acc;
                    restart      = 1'b1;
                end
            end
            5: begin
                if (m_wen) begin
                    m_fc  = m_sr;
                    e_fv  = 1'b1;
                    m_wen = 1'b0;
                end
            end
            7:  begin m_idx = 0; restart = 1'b1; end
            11: begin end
            13: begin m_idx = 0; m_wen = 1'b0; restart = 1'b1; end
            15: m_wen = 1'b1;
            default: e_ce = 1'b1;
        endcase
        if (restart) m_acc = int'(gfall);
        else if (gfall && m_acc < ACC_MAX) m_acc = m_acc + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // Shift a frame, drop lat, and leave the time point where decode results are visible
    task automatic send_frame(input int nbits, input int latbits,
                              input logic [47:0] data, input bit gfall);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.sin = data[i];
            if (i < latbits) bus.lat = 1'b1;
            bus.sclk = 1'b1;
            tick();
            bus.sclk = 1'b0;
            tick();
        end
        if (latbits == 0) begin
            bus.lat = 1'b1;
            tick();
        end
        bus.lat  = 1'b0;
        bus.gclk = gfall;
        tick();
        bus.gclk = 1'b0;
        model_frame(nbits, latbits, data, gfall);
    endtask

    task automatic pulse_width_check(input string name);
        tick();
        check({name, "_pulse_width"},
              {bus.gs_valid, bus.latgs_pulse, bus.fc_valid, bus.cmd_error}, 64'd0);
    endtask

    task automatic gclk_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            bus.gclk = 1'b1;
            tick();
            bus.gclk = 1'b0;
            tick();
            if (m_acc < ACC_MAX) m_acc = m_acc + 1;
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_gs_word"},     bus.gs_word,     64'd0);
        check({name, "_gs_index"},    bus.gs_index,    64'd0);
        check({name, "_gclk_count"},  bus.gclk_count,  64'd0);
        check({name, "_fc_data"},     bus.fc_data,     64'd0);
        check({name, "_gs_overflow"}, bus.gs_overflow, 64'd0);
        check({name, "_pulses"},
              {bus.gs_valid, bus.latgs_pulse, bus.fc_valid, bus.cmd_error}, 64'd0);
    endtask

    task automatic check_model(input string name);
        check({name, "_gs_valid"},    bus.gs_valid,    64'(e_gv));
        check({name, "_latgs"},       bus.latgs_pulse, 64'(e_lp));
        check({name, "_fc_valid"},    bus.fc_valid,    64'(e_fv));
        check({name, "_cmd_error"},   bus.cmd_error,   64'(e_ce));
        check({name, "_gs_word"},     bus.gs_word,     64'(m_gs_word));
        check({name, "_gs_index"},    bus.gs_index,    64'(m_gs_index));
        check({name, "_fc_data"},     bus.fc_data,     64'(m_fc));
        check({name, "_gclk_count"},  bus.gclk_count,  64'(m_gclk_count));
        check({name, "_gs_overflow"}, bus.gs_overflow, 64'(m_ovf));
    endtask

    function automatic logic [47:0] rnd48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    initial begin
        logic [47:0] w;
        int          cmds[7];
        int          lb, nb;
        bit          gf;

        cmds = '{1, 3, 5, 7, 11, 13, 15};
        rst = 1'b1;
        bus.sclk = 1'b0; bus.gclk = 1'b0; bus.lat = 1'b0; bus.sin = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        model_reset();
        check_all_zero("reset");

        // Directed table: command decode, FC write-enable handshake, count boundaries
        vecs[0]  = mk(15, 15, 48'h0,              0, 0, 0, 0, 4'd0, 48'h0,              48'h0);
        vecs[1]  = mk(48,  5, 48'hA5A5_0000_1234, 0, 0, 1, 0, 4'd0, 48'h0,              48'hA5A5_0000_1234);
        vecs[2]  = mk(48,  5, 48'hFFFF_FFFF_FFFF, 0, 0, 0, 0, 4'd0, 48'h0,              48'hA5A5_0000_1234);
        vecs[3]  = mk(48,  1, 48'h1111_2222_3333, 1, 0, 0, 0, 4'd0, 48'h1111_2222_3333, 48'hA5A5_0000_1234);
        vecs[4]  = mk( 4,  4, 48'hF,              0, 0, 0, 1, 4'd0, 48'h1111_2222_3333, 48'hA5A5_0000_1234);
        vecs[5]  = mk(11, 11, 48'h0,              0, 0, 0, 0, 4'd0, 48'h1111_2222_3333, 48'hA5A5_0000_1234);
        vecs[6]  = mk(13, 13, 48'h0,              0, 0, 0, 0, 4'd0, 48'h1111_2222_3333, 48'hA5A5_0000_1234);
        vecs[7]  = mk(48,  1, 48'h0000_0000_0001, 1, 0, 0, 0, 4'd0, 48'h0000_0000_0001, 48'hA5A5_0000_1234);
        vecs[8]  = mk(48,  3, 48'h8000_0000_0000, 1, 1, 0, 0, 4'd1, 48'h8000_0000_0000, 48'hA5A5_0000_1234);
        vecs[9]  = mk(20, 20, 48'h0,              0, 0, 0, 1, 4'd1, 48'h8000_0000_0000, 48'hA5A5_0000_1234);
        vecs[10] = mk( 7,  7, 48'h0,              0, 0, 0, 0, 4'd1, 48'h8000_0000_0000, 48'hA5A5_0000_1234);
        vecs[11] = mk(48,  1, 48'hDEAD_BEEF_CAFE, 1, 0, 0, 0, 4'd0, 48'hDEAD_BEEF_CAFE, 48'hA5A5_0000_1234);
        vecs[12] = mk(33, 33, 48'h0,              0, 0, 0, 1, 4'd0, 48'hDEAD_BEEF_CAFE, 48'hA5A5_0000_1234);
        vecs[13] = mk( 0,  0, 48'h0,              0, 0, 0, 1, 4'd0, 48'hDEAD_BEEF_CAFE, 48'hA5A5_0000_1234);

        for (int v = 0; v < 14; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            send_frame(vecs[v].nbits, vecs[v].latbits, vecs[v].data, 1'b0);
            check({nm, "_gs_valid"},    bus.gs_valid,    64'(vecs[v].gv));
            check({nm, "_latgs"},       bus.latgs_pulse, 64'(vecs[v].lp));
            check({nm, "_fc_valid"},    bus.fc_valid,    64'(vecs[v].fv));
            check({nm, "_cmd_error"},   bus.cmd_error,   64'(vecs[v].ce));
            check({nm, "_gs_index"},    bus.gs_index,    64'(vecs[v].idx));
            check({nm, "_gs_word"},     bus.gs_word,     64'(vecs[v].word));
            check({nm, "_fc_data"},     bus.fc_data,     64'(vecs[v].fc));
            check({nm, "_gs_overflow"}, bus.gs_overflow, 64'd0);
            pulse_width_check(nm);
        end

        // Reset mid-command: partial shift and lat count discarded
        w = rnd48();
        for (int i = 19; i >= 0; i--) begin
            bus.sin = w[i];
            if (i < 3) bus.lat = 1'b1;
            bus.sclk = 1'b1;
            tick();
            bus.sclk = 1'b0;
            tick();
        end
        rst = 1'b1;
        tick();
        check_all_zero("mid_rst");
        rst = 1'b0;
        tick();
        bus.lat = 1'b0;
        tick();
        model_reset();
        model_frame(0, 0, 48'h0, 1'b0);
        check("rst_latfall_cmd_error", bus.cmd_error, 64'd1);
        check("rst_latfall_no_gs", bus.gs_valid, 64'd0);
        pulse_width_check("rst_latfall");
        w = rnd48();
        send_frame(48, 1, w, 1'b0);
        check("post_rst_gs_valid", bus.gs_valid, 64'd1);
        check("post_rst_gs_index", bus.gs_index, 64'd0);
        check("post_rst_gs_word",  bus.gs_word,  64'(w));
        pulse_width_check("post_rst");

        // GS burst: 8 x WRTGS then LATGS fills slots 0..8
        send_frame(13, 13, 48'h0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            string nm;
            nm = $sformatf("burst%0d", k);
            w = rnd48();
            send_frame(48, (k == 8) ? 3 : 1, w, 1'b0);
            check({nm, "_gs_valid"}, bus.gs_valid,    64'd1);
            check({nm, "_gs_index"}, bus.gs_index,    64'(k));
            check({nm, "_gs_word"},  bus.gs_word,     64'(w));
            check({nm, "_latgs"},    bus.latgs_pulse, 64'(k == 8));
            check({nm, "_overflow"}, bus.gs_overflow, 64'd0);
            pulse_width_check(nm);
        end

        // gclk interval: rise in the LATGS cycle belongs to the next interval
        gclk_pulses(72);
        send_frame(48, 3, rnd48(), 1'b1);
        check("gclk72_latgs", bus.latgs_pulse, 64'd1);
        check("gclk72_count", bus.gclk_count, 64'd72);
        pulse_width_check("gclk72");
        gclk_pulses(5);
        send_frame(48, 3, rnd48(), 1'b0);
        check("gclk_carry_count", bus.gclk_count, 64'd6);
        pulse_width_check("gclk_carry");

        // Overflow: 10th WRTGS before LATGS is dropped, flag is sticky
        for (int k = 0; k < 9; k++) send_frame(48, 1, rnd48(), 1'b0);
        check("ovf_after9", bus.gs_overflow, 64'd0);
        w = rnd48();
        send_frame(48, 1, w, 1'b0);
        check("ovf10_gs_valid", bus.gs_valid, 64'd0);
        check("ovf10_flag", bus.gs_overflow, 64'd1);
        check("ovf10_gs_index", bus.gs_index, 64'd8);
        pulse_width_check("ovf10");
        send_frame(48, 3, rnd48(), 1'b0);
        check("ovf_latgs_sticky", bus.gs_overflow, 64'd1);
        w = rnd48();
        send_frame(48, 1, w, 1'b0);
        check("ovf_next_gs_valid", bus.gs_valid, 64'd1);
        check("ovf_next_gs_index", bus.gs_index, 64'd0);
        check("ovf_next_sticky", bus.gs_overflow, 64'd1);
        pulse_width_check("ovf_next");

        // Randomized commands against the reference model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        model_reset();
        check_all_zero("rand_rst");
        for (int t = 0; t < 80; t++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 7)       lb = cmds[r];
            else if (r == 7) lb = 1;
            else if (r == 8) lb = int'($urandom_range(0, 35));
            else             lb = 15;
            nb = ($urandom_range(0, 1) == 1) ? 48 : int'($urandom_range(lb, 48));
            if (nb < lb) nb = lb;
            gf = 1'($urandom_range(0, 1));
            gclk_pulses(int'($urandom_range(0, 3)));
            send_frame(nb, lb, rnd48(), gf);
            check_model($sformatf("rand%0d_c%0d", t, lb));
            pulse_width_check($sformatf("rand%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
